ajuste_pwm_ctrl: RTL and testbench



---
 rtl/ajuste_pwm_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_ajuste_pwm_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ajuste_pwm_ctrl.sv
// ajuste_pwm_ctrl: push-button setpoint controller for frequency/current indices, with auto-repeat.
// Latency: a button level seen before clock edge 1 updates the setpoint and pulses actualizar on edge 3.
// Backpressure: none; steps are applied unconditionally. The optional AUTO_ALT_EN macro adds idle display alternation.
module ajuste_pwm_ctrl #(
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000,
    parameter int FREC_MAX    = 7,
    parameter int CORR_MAX    = 31,
    parameter int ALT_PERIOD  = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic [2:0] Frecuencia,
    output logic [4:0] Corriente,
    output logic       selector_F_I,
    output logic       actualizar
);

    localparam int TMR_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int TW      = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;
    localparam logic [TW-1:0] DLY_LD  = TW'(REPEAT_DLY);
    localparam logic [TW-1:0] RATE_LD = TW'(REPEAT_RATE);
    localparam logic [2:0]    FREC_TOP = 3'(FREC_MAX);
    localparam logic [4:0]    CORR_TOP = 5'(CORR_MAX);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Bit 0 = up, bit 1 = down, bit 2 = sel
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] hist;
    logic [2:0] rise;

    state_t        state;
    logic [TW-1:0] timer;
    logic          dir_up;

    logic          up_lvl;
    logic          dn_lvl;
    logic          both_lvl;
    logic          dir_held;
    logic          timer_done;
    logic          step_req;
    logic          step_up;
    logic [2:0]    frec_inc;
    logic [2:0]    frec_dec;
    logic [4:0]    corr_inc;
    logic [4:0]    corr_dec;
    logic [2:0]    frec_nxt;
    logic [4:0]    corr_nxt;
    logic          changed;

`ifdef AUTO_ALT_EN
    localparam int AW = (ALT_PERIOD > 1) ? $clog2(ALT_PERIOD + 1) : 1;
    localparam logic [AW-1:0] ALT_LAST = AW'(ALT_PERIOD - 1);
    logic [AW-1:0] alt_cnt;
    logic          alt_active;
`else
    logic          alt_active;
    logic          alt_unused;
    assign alt_active = 1'b0;
    assign alt_unused = (ALT_PERIOD != 0);
`endif

    // Two-stage synchroniser plus history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            hist  <= 3'b000;
        end else begin
            sync1 <= {btn_sel, btn_down, btn_up};
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise       = sync2 & ~hist;
    assign up_lvl     = sync2[0];
    assign dn_lvl     = sync2[1];
    assign both_lvl   = up_lvl & dn_lvl;
    assign dir_held   = dir_up ? up_lvl : dn_lvl;
    // Treat 1 as done so the step lands exactly REPEAT_DLY / REPEAT_RATE cycles apart
    assign timer_done = (timer <= TW'(1));

    assign frec_inc = (Frecuencia < FREC_TOP) ? Frecuencia + 3'd1 : Frecuencia;
    assign frec_dec = (Frecuencia != 3'd0)    ? Frecuencia - 3'd1 : Frecuencia;
    assign corr_inc = (Corriente < CORR_TOP)  ? Corriente + 5'd1  : Corriente;
    assign corr_dec = (Corriente != 5'd0)     ? Corriente - 5'd1  : Corriente;

    // Decide whether this cycle produces a step and in which direction; sel and up+down suppress steps
    always_comb begin
        step_req = 1'b0;
        step_up  = dir_up;
        if (!rise[2] && !both_lvl) begin
            case (state)
                IDLE: begin
                    if ((rise[0] ^ rise[1]) && !alt_active) begin
                        step_req = 1'b1;
                        step_up  = rise[0];
                    end
                end
                HOLD, REPEAT: begin
                    if (dir_held && timer_done) begin
                        step_req = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Apply the step to the edit target only, saturating at the limits
    always_comb begin
        frec_nxt = Frecuencia;
        corr_nxt = Corriente;
        if (step_req) begin
            if (selector_F_I) begin
                corr_nxt = step_up ? corr_inc : corr_dec;
            end else begin
                frec_nxt = step_up ? frec_inc : frec_dec;
            end
        end
    end

    assign changed = (frec_nxt != Frecuencia) || (corr_nxt != Corriente);

    // Auto-repeat FSM with registered setpoints, selector and update strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            dir_up       <= 1'b0;
            Frecuencia   <= 3'd0;
            Corriente    <= 5'd0;
            selector_F_I <= 1'b0;
            actualizar   <= 1'b0;
`ifdef AUTO_ALT_EN
            alt_cnt      <= '0;
            alt_active   <= 1'b0;
`endif
        end else begin
            Frecuencia <= frec_nxt;
            Corriente  <= corr_nxt;
            actualizar <= step_req && changed;

            if (rise[2]) begin
                selector_F_I <= ~selector_F_I;
                timer        <= '0;
                state        <= (up_lvl || dn_lvl) ? WAIT_REL : IDLE;
`ifdef AUTO_ALT_EN
                alt_active   <= 1'b0;
`endif
            end else if (both_lvl) begin
                timer <= '0;
                state <= WAIT_REL;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise[0] ^ rise[1]) begin
`ifdef AUTO_ALT_EN
                            if (alt_active) begin
                                // First press while alternating only freezes the display
                                alt_active <= 1'b0;
                                state      <= WAIT_REL;
                            end else begin
                                dir_up <= rise[0];
                                timer  <= DLY_LD;
                                state  <= HOLD;
                            end
`else
                            dir_up <= rise[0];
                            timer  <= DLY_LD;
                            state  <= HOLD;
`endif
                        end
                    end
                    HOLD, REPEAT: begin
                        if (!dir_held) begin
                            timer <= '0;
                            state <= IDLE;
                        end else if (timer_done) begin
                            timer <= RATE_LD;
                            state <= REPEAT;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    WAIT_REL: begin
                        if (!up_lvl && !dn_lvl) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

`ifdef AUTO_ALT_EN
            // Inactivity counter: any pressed level restarts it, expiry toggles the display
            if (sync2 != 3'b000) begin
                alt_cnt <= '0;
            end else if (alt_cnt >= ALT_LAST) begin
                alt_cnt      <= '0;
                selector_F_I <= ~selector_F_I;
                alt_active   <= 1'b1;
            end else begin
                alt_cnt <= alt_cnt + AW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_ajuste_pwm_ctrl.sv
// tb_ajuste_pwm_ctrl: scoreboard bench for the setpoint controller.
// Stimulus pushes {cycle, F, I, sel} per expected actualizar pulse; a monitor pops on each pulse.
// Direct checks cover reset, asynchronous reset, saturation and selector behaviour.
module tb_ajuste_pwm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic [2:0] Frecuencia;
    logic [4:0] Corriente;
    logic       selector_F_I;
    logic       actualizar;

    typedef struct {
        int cyc;
        int f;
        int c;
        int s;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ajuste_pwm_ctrl #(
        .REPEAT_DLY (8),
        .REPEAT_RATE(4),
        .FREC_MAX   (7),
        .CORR_MAX   (31),
        .ALT_PERIOD (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_sel     (btn_sel),
        .Frecuencia  (Frecuencia),
        .Corriente   (Corriente),
        .selector_F_I(selector_F_I),
        .actualizar  (actualizar)
    );

    always #5 clk = ~clk;

    // Posedge counter used to timestamp expected updates
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every actualizar pulse must match the oldest expected update
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_update: no pulse at cycle %0d, expected F=%0d I=%0d sel=%0d",
                     mon_e.cyc, mon_e.f, mon_e.c, mon_e.s);
        end
        if (rst_n === 1'b1 && actualizar === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_update: pulse at cycle %0d with F=%0d I=%0d, required none",
                         cyc, Frecuencia, Corriente);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc != cyc || int'(Frecuencia) != mon_e.f ||
                    int'(Corriente) != mon_e.c || int'(selector_F_I) != mon_e.s) begin
                    n_bad++;
                    $display("FAIL update: got cyc=%0d F=%0d I=%0d sel=%0d, required cyc=%0d F=%0d I=%0d sel=%0d",
                             cyc, Frecuencia, Corriente, selector_F_I,
                             mon_e.cyc, mon_e.f, mon_e.c, mon_e.s);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int dly, input int f, input int c, input int s);
        exp_t e;
        e.cyc = cyc + dly;
        e.f   = f;
        e.c   = c;
        e.s   = s;
        sb_q.push_back(e);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_up   = v;
            1:       btn_down = v;
            default: btn_sel  = v;
        endcase
    endtask

    // Hold one button for len cycles, then release and let synchronisers settle
    task automatic press(input int b, input int len);
        set_btn(b, 1'b1);
        tick(len);
        set_btn(b, 1'b0);
        tick(5);
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_sel  = 1'b0;
        tick(2);
        chk("rst_frec", 32'(Frecuencia), 0);
        chk("rst_corr", 32'(Corriente), 0);
        chk("rst_sel", 32'(selector_F_I), 0);
        chk("rst_act", 32'(actualizar), 0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_frec", 32'(Frecuencia), 0);
        chk("post_rst_act", 32'(actualizar), 0);

        // Single short up press: 0 -> 1 on edge 3
        push_exp(3, 1, 0, 0);
        press(0, 3);
        chk("pulse_corr", 32'(Corriente), 0);

        // Step frequency up to 5
        for (int v = 2; v <= 5; v++) begin
            push_exp(3, v, 0, 0);
            press(0, 3);
        end

        // Long hold: 6 at edge 3, 7 eight cycles later, then saturated
        push_exp(3, 6, 0, 0);
        push_exp(11, 7, 0, 0);
        press(0, 40);
        chk("sat_frec", 32'(Frecuencia), 7);

        // Toggle edit target to current
        press(2, 3);
        chk("sel_toggle", 32'(selector_F_I), 1);
        chk("sel_frec", 32'(Frecuencia), 7);
        push_exp(3, 7, 1, 1);
        press(0, 3);
        push_exp(3, 7, 2, 1);
        press(0, 3);

        // Hold down from 2: 1, then 0 after REPEAT_DLY, stays 0
        push_exp(3, 7, 1, 1);
        push_exp(11, 7, 0, 1);
        press(1, 30);
        chk("down_corr", 32'(Corriente), 0);
        chk("down_frec", 32'(Frecuencia), 7);
        chk("down_sel", 32'(selector_F_I), 1);

        // Up and down together: no step
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(12);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(5);
        chk("both_corr", 32'(Corriente), 0);
        chk("both_frec", 32'(Frecuencia), 7);
        push_exp(3, 7, 1, 1);
        press(0, 3);

        // Hold up into REPEAT up to 12, then asynchronous reset mid-repeat
        push_exp(3, 7, 2, 1);
        push_exp(11, 7, 3, 1);
        for (int v = 4; v <= 12; v++) push_exp(15 + 4 * (v - 4), 7, v, 1);
        btn_up = 1'b1;
        tick(49);
        chk("repeat_corr", 32'(Corriente), 12);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_frec", 32'(Frecuencia), 0);
        chk("arst_corr", 32'(Corriente), 0);
        chk("arst_sel", 32'(selector_F_I), 0);
        chk("arst_act", 32'(actualizar), 0);
        btn_up = 1'b0;
        tick(3);
        rst_n = 1'b1;
        chk("queue_after_repeat", 32'(sb_q.size()), 0);

`ifdef AUTO_ALT_EN
        tick(19);
        chk("alt_before", 32'(selector_F_I), 0);
        tick(1);
        chk("alt_first", 32'(selector_F_I), 1);
        tick(19);
        chk("alt_hold", 32'(selector_F_I), 1);
        tick(1);
        chk("alt_second", 32'(selector_F_I), 0);
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        tick(12);
        chk("alt_stop_sel", 32'(selector_F_I), 0);
        chk("alt_stop_frec", 32'(Frecuencia), 0);
`else
        tick(45);
        chk("no_alt_sel", 32'(selector_F_I), 0);
        chk("no_alt_frec", 32'(Frecuencia), 0);
        chk("no_alt_corr", 32'(Corriente), 0);
`endif

        tick(2);
        chk("queue_final", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
